uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter MAIN_CLK, default 100000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port data_in  input  DATA_BITS  word to transmit.
REQ-008 SHALL have port data_in_valid  input  1  producer offers data_in.
REQ-009 SHALL have port data_in_ready  output  1  block accepts data_in this cycle.
REQ-010 SHALL have port parity_odd  input  1  parity select, 1 = odd, 0 = even.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port tx  output  1  serial line, idle high, driven from a flop.

Function
REQ-013 SHALL define BAUD_DIVIDE = MAIN_CLK/BAUD (integer division), with every bit period exactly BAUD_DIVIDE clk cycles; the divider counts 0..BAUD_DIVIDE-1 and is sized $clog2(BAUD_DIVIDE).
REQ-014 SHALL treat BAUD_DIVIDE < 2, DATA_BITS outside 5..9, or STOP_BITS outside {1,2} as illegal, flagged by an elaboration-time check.
REQ-015 SHALL transfer a word on any rising edge where data_in_valid && data_in_ready, capturing data_in, parity_odd and the computed parity bit into internal registers.
REQ-016 SHALL run the state machine IDLE -> START -> DATA -> PARITY (only when enabled, see REQ-027) -> STOP -> IDLE/START, each state lasting whole bit periods.
REQ-017 SHALL drive tx low from the edge of acceptance (zero-cycle latency: the start bit appears on the cycle after the accepting edge) for one bit period.
REQ-018 SHALL transmit DATA as DATA_BITS bit periods, LSB first, using the captured word only; changes on data_in after acceptance SHALL have no effect.
REQ-019 SHALL hold tx high for STOP_BITS bit periods in STOP.
REQ-020 SHALL assert data_in_ready in IDLE, and in the final clk cycle of the last stop bit only; it SHALL be low at all other times.
REQ-021 SHALL, on acceptance in the final stop cycle, enter START directly with no idle gap; otherwise it SHALL enter IDLE with tx=1.
REQ-022 SHALL assert busy in every state except IDLE, including the back-to-back transition.
REQ-023 SHALL NOT allow data_in_ready to depend combinationally on data_in_valid.

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk, force state IDLE, divider 0, tx=1, busy=0, data_in_ready=1, and capture registers 0.
REQ-025 SHALL abort any frame in progress when reset asserts mid-frame and SHALL NOT resume it afterward.
REQ-026 SHALL allow acceptance on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro UART_TX_CFG_PARITY_EN defined, insert one PARITY bit period after DATA carrying XOR(data) for even parity or ~XOR(data) for odd parity, as selected by the captured parity_odd.
REQ-028 SHALL, without UART_TX_CFG_PARITY_EN, omit the PARITY state, keep the parity_odd port present but ignored, and give a frame length of 1+DATA_BITS+STOP_BITS bits.

Verification (MAIN_CLK=8, BAUD=1, so BAUD_DIVIDE=8, unless stated)
REQ-029 SHALL cover: reset release -> tx=1, busy=0, data_in_ready=1.
REQ-030 SHALL cover: no parity, DATA_BITS=8, STOP_BITS=1, send 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 8 cycles, 80 cycles total, busy high for exactly 80 cycles.
REQ-031 SHALL cover: UART_TX_CFG_PARITY_EN defined, send 0x07 -> parity bit 1 with parity_odd=0 and 0 with parity_odd=1; frame 88 cycles.
REQ-032 SHALL cover: 0xA5 then 0x3C with valid held -> data_in_ready high one cycle at the last stop cycle, second start bit immediately follows stop, busy never drops.
REQ-033 SHALL cover: STOP_BITS=2, DATA_BITS=5, send 0x1F -> 5 data bits high, then stop high for 16 cycles before ready.
REQ-034 SHALL cover: rst_n pulled low during data bit 3 of 0x00 -> tx=1 without waiting for a clk edge, busy=0, no further frame bits after release.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- configurable UART transmitter.
//
// Sends 1 start bit, DATA_BITS data bits (LSB first), an optional parity bit
// and STOP_BITS stop bits. Every bit lasts MAIN_CLK/BAUD clk cycles.
//
// Optional feature macro: UART_TX_CFG_PARITY_EN
//   defined   -> one parity bit follows the data bits
//                (even: XOR of the data, odd: its inverse, chosen by parity_odd)
//   undefined -> no parity bit; parity_odd is present but ignored
//
// Parameters:
//   MAIN_CLK  clock frequency in Hz
//   BAUD      line rate in bit/s
//   DATA_BITS data bits per frame (5..9)
//   STOP_BITS stop bits per frame (1 or 2)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   data_in        word to transmit
//   data_in_valid  producer offers data_in
//   data_in_ready  word is accepted on this cycle's rising edge if valid
//   parity_odd     1 = odd parity, 0 = even parity
//   busy           frame in progress
//   tx             serial line, idle high, registered
module uart_tx_cfg #(
  parameter int MAIN_CLK  = 100000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  input  logic                 parity_odd,
  output logic                 busy,
  output logic                 tx
);

  localparam int BAUD_DIVIDE = MAIN_CLK / BAUD;
  localparam int DIVW        = $clog2(BAUD_DIVIDE);
  localparam int BCW         = $clog2(DATA_BITS);

  if (BAUD_DIVIDE < 2) begin : g_bad_divide
    $error("uart_tx_cfg: MAIN_CLK/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_CFG_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DIVW-1:0]       div_q, div_d;
  logic [BCW-1:0]        bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  tx_d;
  logic                  bit_end;
  logic                  accept;

`ifdef UART_TX_CFG_PARITY_EN
  logic                  par_q, par_d;
`else
  logic                  unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign bit_end = (div_q == DIVW'(BAUD_DIVIDE - 1));

  // Ready depends on registered state only, never on data_in_valid.
  assign data_in_ready = (state_q == IDLE) ||
                         ((state_q == STOP) && (stop_q == 1'(STOP_BITS - 1)) && bit_end);
  assign accept        = data_in_valid && data_in_ready;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_CFG_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      tx      <= tx_d;
`ifdef UART_TX_CFG_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
`ifdef UART_TX_CFG_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE) begin
      div_d = bit_end ? '0 : div_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        div_d = '0;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
          if (bit_q == BCW'(DATA_BITS - 1)) begin
`ifdef UART_TX_CFG_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_CFG_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase

    // Acceptance overrides the normal step; in the last stop cycle this
    // turns the IDLE exit into a direct START with no idle gap.
    if (accept) begin
      state_d = START;
      div_d   = '0;
      shreg_d = data_in;
`ifdef UART_TX_CFG_PARITY_EN
      par_d   = (^data_in) ^ parity_odd;
`endif
    end

    // tx is registered from the next-state decode so the line level
    // lines up exactly with the state it belongs to.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_CFG_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule
